uart_tx_dev: RTL and testbench

Memory-mapped UART transmitter that hangs off the south bridge as a peer of the two timers, exposing the same word-addressed register port (Addr, WE, Din, Dout, IRQ). The CPU writes bytes into a small transmit FIFO. A bit-serial shifter drains the FIFO onto a single TxD line as 8N1 frames at a programmable rate. IRQ is a level request routed to one HWInt line.

---
 rtl/uart_tx_dev.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register port, small transmit FIFO and a
// bit-serial shifter driving a registered TxD line at a programmable bit rate.
`timescale 1ns/1ps

module uart_tx_dev #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        TxD
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_DATA   = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_DIV    = 2'd3;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_en;
   logic          r_ie;
   logic          r_ovf;
   logic [15:0]   r_div;
   logic [1:0]    r_state;
   logic          r_lead;
   logic [2:0]    r_bit;
   logic [15:0]   r_cnt;
   logic [7:0]    r_shift;
   logic          r_txd;

   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic [15:0]   w_dive;
   logic          w_tick;
   logic          w_pop;
   logic          w_wr_data;
   logic          w_push;
   logic [7:0]    w_head;
   logic [4:0]    w_count5;
   logic          w_unused;

   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_busy    = (r_state != S_IDLE);
   assign w_dive    = (r_div == 16'd0) ? 16'd1 : r_div;
   // Compared against the live divisor; >= keeps a lowered DIV from overrunning a bit.
   assign w_tick    = (r_cnt >= w_dive - 16'd1);
   assign w_pop     = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick)) && r_en && !w_empty;
   assign w_wr_data = WE && (Addr[3:2] == A_DATA);
   assign w_push    = w_wr_data && (!w_full || w_pop);
   assign w_head    = r_mem[r_rptr];
   assign w_count5  = 5'(r_count);
   assign w_unused  = ^{Addr[31:4], Din[31:16]};

   // NOTE: storage carries no reset; the pointers and count alone define FIFO contents.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= Din[7:0];
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en    <= 1'b0;
         r_ie    <= 1'b0;
         r_div   <= 16'd0;
         r_ovf   <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (WE && (Addr[3:2] == A_CTRL)) begin
            r_en <= Din[0];
            r_ie <= Din[1];
         end
         if (WE && (Addr[3:2] == A_DIV)) r_div <= Din[15:0];

         if (WE && (Addr[3:2] == A_STATUS)) r_ovf <= 1'b0;
         else if (w_wr_data && w_full && !w_pop) r_ovf <= 1'b1;

         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A pop from IDLE spends one lead cycle in START before the start bit appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_lead  <= 1'b0;
         r_bit   <= 3'd0;
         r_cnt   <= 16'd0;
         r_shift <= 8'd0;
         r_txd   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_head;
                  r_state <= S_START;
                  r_lead  <= 1'b1;
                  r_cnt   <= 16'd0;
               end
            end
            S_START: begin
               if (r_lead) begin
                  r_lead <= 1'b0;
                  r_txd  <= 1'b0;
               end else if (w_tick) begin
                  r_state <= S_DATA;
                  r_bit   <= 3'd0;
                  r_cnt   <= 16'd0;
                  r_txd   <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_cnt <= 16'd0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_txd   <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_cnt <= 16'd0;
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_state <= S_START;
                     r_txd   <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: default assignment first so no path through the case leaves Dout latched.
   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         A_CTRL:   Dout = {30'd0, r_ie, r_en};
         A_DATA:   Dout = 32'd0;
         A_STATUS: Dout = {23'd0, w_count5, r_ovf, w_empty, w_full, w_busy};
         A_DIV:    Dout = {16'd0, r_div};
         default:  Dout = 32'd0;
      endcase
   end

   assign IRQ = r_ie && w_empty && !w_busy;
   assign TxD = r_txd;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: directed scenarios plus randomized frames
// compared against a bit-timing model of 8N1 framing.
`timescale 1ns/1ps

module tb_uart_tx_dev;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        TxD;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   uart_tx_dev #(.FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ),
      .TxD  (TxD)
   );

   // Write lands on the posedge between the two negedges; returns in that cycle.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(negedge clk);
      WE   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      Addr = {28'd0, a};
      #1;
      d = Dout;
   endtask

   task automatic do_reset();
      @(negedge clk);
      WE    = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Line level at cycle i of a frame: start bit, eight data bits LSB first, stop bit.
   function automatic logic exp_bit(input logic [7:0] b, input int d, input int i);
      int k;
      k = i / d;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      rd(2'd0, v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h want %h", v, 32'd0); end
      rd(2'd1, v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want %h", v, 32'd0); end
      rd(2'd2, v); total++;
      if (v !== 32'h4) begin bad++; $display("FAIL reset_status: got %h want %h", v, 32'h4); end
      rd(2'd3, v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_div: got %h want %h", v, 32'd0); end
      total++;
      if (TxD !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", TxD); end
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", IRQ); end
   endtask

   // Sends one byte from IDLE with EN set and checks line timing and BUSY fall.
   task automatic test_frame(input string name, input logic [7:0] b, input int d);
      logic [255:0] act, exp;
      logic pre_tx, busy_hi, busy_lo, post_tx;
      int n;
      n = 10 * d;
      act = '0;
      exp = '0;
      for (int i = 0; i < n; i++) exp[i] = exp_bit(b, d, i);
      wr(2'd1, {24'd0, b});
      Addr = 30'd2;
      for (int j = 0; j < n + 2; j++) begin
         @(negedge clk);
         #1;
         if (j == 0) pre_tx = TxD;
         if (j >= 1 && j <= n) act[j-1] = TxD;
         if (j == n) busy_hi = Dout[0];
         if (j == n + 1) begin busy_lo = Dout[0]; post_tx = TxD; end
      end
      total++;
      if (pre_tx !== 1'b1) begin bad++; $display("FAIL %s_pre: got %b want 1", name, pre_tx); end
      total++;
      if (act !== exp) begin bad++; $display("FAIL %s_bits: got %h want %h", name, act, exp); end
      total++;
      if (busy_hi !== 1'b1) begin bad++; $display("FAIL %s_busy_end: got %b want 1", name, busy_hi); end
      total++;
      if (busy_lo !== 1'b0) begin bad++; $display("FAIL %s_busy_fall: got %b want 0", name, busy_lo); end
      total++;
      if (post_tx !== 1'b1) begin bad++; $display("FAIL %s_idle: got %b want 1", name, post_tx); end
   endtask

   task automatic test_single_frame();
      wr(2'd3, 32'd4);
      wr(2'd0, 32'd1);
      test_frame("single_a5", 8'hA5, 4);
   endtask

   // Fills the FIFO with EN clear, checks STATUS, then drains it as one stream.
   task automatic test_burst(input string name, input int nwrite, input int dreg);
      logic [7:0] q[$];
      logic [7:0] b;
      logic [31:0] v, want;
      logic [255:0] act, exp;
      logic ovf, pre_tx, busy_hi;
      logic [31:0] st_end;
      int d, n, fl;
      d = (dreg == 0) ? 1 : dreg;
      ovf = 1'b0;
      wr(2'd0, 32'd0);
      wr(2'd3, dreg);
      for (int i = 0; i < nwrite; i++) begin
         b = 8'($urandom);
         wr(2'd1, {$urandom, b} >> 0);
         if (q.size() < DEPTH) q.push_back(b);
         else ovf = 1'b1;
      end
      want = (q.size() << 4) | (ovf << 3) | ((q.size() == 0) << 2) | ((q.size() == DEPTH) << 1);
      rd(2'd2, v); total++;
      if (v !== want) begin bad++; $display("FAIL %s_status: got %h want %h", name, v, want); end
      if (ovf) begin
         wr(2'd2, 32'hFFFF_FFFF);
         want = want & ~32'h8;
         rd(2'd2, v); total++;
         if (v !== want) begin bad++; $display("FAIL %s_ovf_clear: got %h want %h", name, v, want); end
      end
      fl = 10 * d;
      n = fl * q.size();
      act = '0;
      exp = '0;
      for (int i = 0; i < n; i++) exp[i] = exp_bit(q[i / fl], d, i % fl);
      wr(2'd0, 32'd1);
      Addr = 30'd2;
      for (int j = 0; j < n + 2; j++) begin
         @(negedge clk);
         #1;
         if (j == 0) pre_tx = TxD;
         if (j >= 1 && j <= n) act[j-1] = TxD;
         if (j == n) busy_hi = Dout[0];
         if (j == n + 1) st_end = Dout;
      end
      total++;
      if (pre_tx !== 1'b1) begin bad++; $display("FAIL %s_pre: got %b want 1", name, pre_tx); end
      total++;
      if (act !== exp) begin bad++; $display("FAIL %s_stream: got %h want %h", name, act, exp); end
      total++;
      if (busy_hi !== 1'b1) begin bad++; $display("FAIL %s_busy_end: got %b want 1", name, busy_hi); end
      total++;
      if (st_end !== 32'h4) begin bad++; $display("FAIL %s_status_end: got %h want %h", name, st_end, 32'h4); end
   endtask

   task automatic test_overflow();
      test_burst("overflow", 5, 2);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++)
         test_burst("b2b", $urandom_range(1, DEPTH), $urandom_range(0, 3));
   endtask

   task automatic test_interrupt();
      logic seen_hi, busy_seen;
      logic [31:0] v;
      wr(2'd3, 32'd1);
      wr(2'd0, 32'd3);
      #1; total++;
      if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_idle_empty: got %b want 1", IRQ); end
      wr(2'd1, 32'd0);
      Addr = 30'd2;
      seen_hi = 1'b0;
      busy_seen = 1'b1;
      for (int j = 0; j < 12; j++) begin
         if (j > 0) @(negedge clk);
         #1;
         if (IRQ !== 1'b0) seen_hi = 1'b1;
         if (j > 0 && Dout[0] !== 1'b1) busy_seen = 1'b0;
      end
      total++;
      if (seen_hi !== 1'b0) begin bad++; $display("FAIL irq_busy: got %b want 0", seen_hi); end
      total++;
      if (busy_seen !== 1'b1) begin bad++; $display("FAIL irq_busy_flag: got %b want 1", busy_seen); end
      @(negedge clk);
      #1; total++;
      if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1", IRQ); end
      wr(2'd1, 32'h55);
      #1; total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_push: got %b want 0", IRQ); end
      repeat (14) @(negedge clk);
      #1; total++;
      if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_drained: got %b want 1", IRQ); end
      wr(2'd0, 32'd1);
      #1; total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_ie_clear: got %b want 0", IRQ); end
      rd(2'd0, v); total++;
      if (v !== 32'd1) begin bad++; $display("FAIL irq_ctrl: got %h want %h", v, 32'd1); end
   endtask

   task automatic test_div0();
      wr(2'd3, 32'd0);
      wr(2'd0, 32'd1);
      test_frame("div0_ff", 8'hFF, 1);
   endtask

   task automatic test_random_frames();
      int dreg;
      wr(2'd0, 32'd1);
      for (int k = 0; k < 6; k++) begin
         dreg = $urandom_range(0, 5);
         wr(2'd3, dreg);
         test_frame("rand", 8'($urandom), (dreg == 0) ? 1 : dreg);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] v;
      logic low_seen;
      wr(2'd3, 32'd3);
      wr(2'd0, 32'd1);
      wr(2'd1, {24'd0, 8'($urandom)});
      wr(2'd1, 32'h00);
      repeat (8) @(negedge clk);
      do_reset();
      #1; total++;
      if (TxD !== 1'b1) begin bad++; $display("FAIL rstmid_txd: got %b want 1", TxD); end
      rd(2'd2, v); total++;
      if (v !== 32'h4) begin bad++; $display("FAIL rstmid_status: got %h want %h", v, 32'h4); end
      rd(2'd0, v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rstmid_ctrl: got %h want %h", v, 32'd0); end
      rd(2'd3, v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rstmid_div: got %h want %h", v, 32'd0); end
      low_seen = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (TxD !== 1'b1) low_seen = 1'b1;
      end
      total++;
      if (low_seen !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: got %b want 0", low_seen); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_back_to_back();
      test_interrupt();
      test_div0();
      test_random_frames();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
